// File: rtl/fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// fetch_queue_stage
//
// Instruction-fetch stage: holds the fetch PC, issues requests to a
// synchronous-read instruction memory (1-cycle latency), buffers returned
// instructions with their PCs in a small FIFO and presents the head entry
// to decode.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous reset, active low
//   redirect_i     in   execute redirect (taken branch / jump)
//   redirect_pc_i  in   redirect target PC
//   imem_req_o     out  fetch request issued this cycle
//   imem_addr_o    out  fetch address (current PC)
//   imem_rdata_i   in   instruction, valid the cycle after its request
//   valid_o        out  queue head holds a valid instruction
//   ready_i        in   decode accepts the head this cycle
//   instr_o        out  head instruction
//   pc_o           out  head PC
//   pc_plus4_o     out  head PC + 4
//   count_o        out  queue occupancy
//
// Handshake: an entry moves from the queue to decode on every rising edge
// where valid_o and ready_i are both high. valid_o never depends on ready_i,
// and once raised it stays high (with stable instr_o/pc_o) until that edge,
// unless a redirect or reset clears the queue.
// ---------------------------------------------------------------------------
module fetch_queue_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter int               FQ_DEPTH = 4,
    parameter int               CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_i,
    input  logic [XLEN-1:0]  redirect_pc_i,
    output logic             imem_req_o,
    output logic [XLEN-1:0]  imem_addr_o,
    input  logic [XLEN-1:0]  imem_rdata_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  pc_plus4_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(FQ_DEPTH);

    // Fetch state
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_req_pc;
    logic             r_inflight;

    // Queue state
    logic [XLEN-1:0]  r_instr_q [FQ_DEPTH];
    logic [XLEN-1:0]  r_pc_q    [FQ_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic [CNT_W:0]   w_credit_sum;
    logic             w_has_credit;
    logic             w_req;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;

    // A request is only issued when the entry it will produce is guaranteed
    // a slot: occupied entries plus the one still in flight must leave room.
    // Pops in the current cycle are deliberately not counted as free space,
    // which keeps this path independent of ready_i.
    assign w_credit_sum = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_has_credit = (w_credit_sum < (CNT_W + 1)'(FQ_DEPTH));
    assign w_req        = rst_n & ~redirect_i & w_has_credit;

    assign w_valid = (r_count != '0);

    // A redirect discards the response arriving this cycle and the head
    // consumed by decode; the whole queue is cleared instead.
    assign w_push = r_inflight & ~redirect_i;
    assign w_pop  = w_valid & ready_i & ~redirect_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect_i) begin
            r_pc       <= redirect_pc_i;
            r_inflight <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_req) begin
                r_pc     <= r_pc + XLEN'(4);
                r_req_pc <= r_pc;
            end
            r_inflight <= w_req;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload carries no reset; it is only observed while valid_o
    // is high, and otherwise simply holds its last contents.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_instr_q[r_wr_ptr] <= imem_rdata_i;
            r_pc_q[r_wr_ptr]    <= r_req_pc;
        end
    end

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_pc;
    assign valid_o     = w_valid;
    assign instr_o     = r_instr_q[r_rd_ptr];
    assign pc_o        = r_pc_q[r_rd_ptr];
    assign pc_plus4_o  = r_pc_q[r_rd_ptr] + XLEN'(4);
    assign count_o     = r_count;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue_stage
//
// Directed bench for fetch_queue_stage. Two instances share clk/rst_n: the
// main one with RESET_PC = 0, and a second one with RESET_PC = 0xFFFF_FFF8
// that streams continuously for the PC wrap scenario. Each instance has a
// 1-cycle synchronous memory model returning (addr >> 2) + 0x13.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_queue_stage;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 4;
  localparam int CNT_W    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             redirect = 1'b0;
  logic [XLEN-1:0]  redirect_pc = '0;
  logic             ready = 1'b0;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata = '0;
  logic             valid;
  logic [XLEN-1:0]  instr;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic [CNT_W-1:0] count;

  logic             hi_redirect = 1'b0;
  logic [XLEN-1:0]  hi_redirect_pc = '0;
  logic             hi_ready = 1'b1;
  logic             hi_req;
  logic [XLEN-1:0]  hi_addr;
  logic [XLEN-1:0]  hi_rdata = '0;
  logic             hi_valid;
  logic [XLEN-1:0]  hi_instr;
  logic [XLEN-1:0]  hi_pc;
  logic [XLEN-1:0]  hi_pc_plus4;
  logic [CNT_W-1:0] hi_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue_stage #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .FQ_DEPTH(FQ_DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .valid_o(valid), .ready_i(ready), .instr_o(instr), .pc_o(pc),
    .pc_plus4_o(pc_plus4), .count_o(count)
  );

  fetch_queue_stage #(.XLEN(XLEN), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(FQ_DEPTH)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .redirect_i(hi_redirect), .redirect_pc_i(hi_redirect_pc),
    .imem_req_o(hi_req), .imem_addr_o(hi_addr), .imem_rdata_i(hi_rdata),
    .valid_o(hi_valid), .ready_i(hi_ready), .instr_o(hi_instr), .pc_o(hi_pc),
    .pc_plus4_o(hi_pc_plus4), .count_o(hi_count)
  );

  function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
    return (a >> 2) + 32'h13;
  endfunction

  always @(posedge clk) begin
    if (imem_req === 1'b1) imem_rdata <= mem_word(imem_addr);
    if (hi_req === 1'b1) hi_rdata <= mem_word(hi_addr);
  end

  // Occupancy must never exceed the queue depth.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (count > CNT_W'(FQ_DEPTH)) begin
        errors++;
        $display("FAIL overflow: count_o=%0d exceeds depth %0d", count, FQ_DEPTH);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench 1 unit after the edge that starts cycle 0 (first cycle
  // out of reset).
  task automatic do_reset(input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    ready       = rdy;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (valid !== 1'b0 || imem_req !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b req=%b count=%0d want 0 0 0", valid, imem_req, count);
    end
    do_reset(1'b1);
    sample();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    sample();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_c0_valid: got %b want 0", valid);
    end
    next_cycle();
    sample();
    checks++;
    if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL stream_c1: valid=%b req=%b addr=%h want 0 1 00000004", valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * i) || instr !== 32'(32'h13 + i) || pc_plus4 !== 32'(4 * i + 4)) begin
        errors++;
        $display("FAIL stream_head%0d: valid=%b pc=%h instr=%h pc4=%h want 1 %h %h %h",
                 i, valid, pc, instr, pc_plus4, 32'(4 * i), 32'(32'h13 + i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_full();
    int exp_cnt [8] = '{0, 0, 1, 2, 3, 4, 4, 4};
    logic exp_req [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset(1'b0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      sample();
      checks++;
      if (count !== CNT_W'(exp_cnt[c]) || imem_req !== exp_req[c]) begin
        errors++;
        $display("FAIL full_c%0d: count=%0d req=%b want %0d %b", c, count, imem_req, exp_cnt[c], exp_req[c]);
      end
    end
    next_cycle();
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      sample();
      checks++;
      if (valid !== 1'b1 || pc !== 32'(4 * i) || instr !== 32'(32'h13 + i)) begin
        errors++;
        $display("FAIL full_drain%0d: valid=%b pc=%h instr=%h want 1 %h %h",
                 i, valid, pc, instr, 32'(4 * i), 32'(32'h13 + i));
      end
      if (i == 0) begin
        checks++;
        if (imem_req !== 1'b0) begin
          errors++;
          $display("FAIL full_pop_no_credit: req=%b want 0", imem_req);
        end
      end
      if (i == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          errors++;
          $display("FAIL full_resume: req=%b addr=%h want 1 00000010", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    sample();
    checks++;
    if (count !== 3'd3 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL redir_cycle: count=%0d req=%b want 3 0", count, imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    ready    = 1'b1;
    sample();
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_t1: count=%0d valid=%b req=%b addr=%h want 0 0 1 00000100",
               count, valid, imem_req, imem_addr);
    end
    next_cycle();
    sample();
    checks++;
    if (count !== 3'd0 || valid !== 1'b0 || imem_addr !== 32'h104) begin
      errors++;
      $display("FAIL redir_t2_stale: count=%0d valid=%b addr=%h want 0 0 00000104", count, valid, imem_addr);
    end
    next_cycle();
    sample();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h100 || instr !== 32'h53) begin
      errors++;
      $display("FAIL redir_t3: valid=%b pc=%h instr=%h want 1 00000100 00000053", valid, pc, instr);
    end
    next_cycle();
    sample();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h104 || instr !== 32'h54) begin
      errors++;
      $display("FAIL redir_t4: valid=%b pc=%h instr=%h want 1 00000104 00000054", valid, pc, instr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    repeat (3) next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    sample();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h4 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pop_redir: valid=%b pc=%h req=%b want 1 00000004 0", valid, pc, imem_req);
    end
    next_cycle();
    redirect_pc = 32'h300;
    sample();
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: valid=%b count=%0d req=%b want 0 0 0", valid, count, imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    sample();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300 || count !== 3'd0) begin
      errors++;
      $display("FAIL b2b_target: req=%b addr=%h count=%0d want 1 00000300 0", imem_req, imem_addr, count);
    end
    next_cycle();
    sample();
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || imem_addr !== 32'h304) begin
      errors++;
      $display("FAIL b2b_no_200: valid=%b count=%0d addr=%h want 0 0 00000304", valid, count, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      sample();
      checks++;
      if (valid !== 1'b1 || pc !== 32'(32'h300 + 4 * i) || instr !== 32'(32'hD3 + i)) begin
        errors++;
        $display("FAIL b2b_head%0d: valid=%b pc=%h instr=%h want 1 %h %h",
                 i, valid, pc, instr, 32'(32'h300 + 4 * i), 32'(32'hD3 + i));
      end
    end
  endtask

  task automatic test_pc_wrap();
    logic [XLEN-1:0] exp_pc    [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    logic [XLEN-1:0] exp_instr [3] = '{32'h4000_0011, 32'h4000_0012, 32'h0000_0013};
    logic [XLEN-1:0] exp_pc4   [3] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset(1'b1);
    sample();
    checks++;
    if (hi_req !== 1'b1 || hi_addr !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL wrap_first_req: req=%b addr=%h want 1 fffffff8", hi_req, hi_addr);
    end
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      checks++;
      if (hi_valid !== 1'b1 || hi_pc !== exp_pc[i] || hi_instr !== exp_instr[i] || hi_pc_plus4 !== exp_pc4[i]) begin
        errors++;
        $display("FAIL wrap_head%0d: valid=%b pc=%h instr=%h pc4=%h want 1 %h %h %h",
                 i, hi_valid, hi_pc, hi_instr, hi_pc_plus4, exp_pc[i], exp_instr[i], exp_pc4[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    repeat (3) next_cycle();
    sample();
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL areset_setup: count=%0d want 2", count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL areset_immediate: valid=%b count=%0d req=%b want 0 0 0", valid, count, imem_req);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    sample();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL areset_restart: req=%b addr=%h valid=%b want 1 00000000 0", imem_req, imem_addr, valid);
    end
    next_cycle();
    sample();
    checks++;
    if (valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL areset_no_stale: valid=%b count=%0d want 0 0", valid, count);
    end
    next_cycle();
    sample();
    checks++;
    if (valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h13 || count !== 3'd1) begin
      errors++;
      $display("FAIL areset_first: valid=%b pc=%h instr=%h count=%0d want 1 00000000 00000013 1",
               valid, pc, instr, count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_back_to_back();
    test_pc_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised next-generation instruction-fetch stage for the pipelined RISC-V core. It holds the fetch PC with a configurable reset vector and issues requests to a synchronous-read instruction memory. Returned instructions are buffered in a small FIFO fetch queue, and each entry is handed to decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard any in-flight fetch.

Parameters:
XLEN, 32, width of PC, addresses and instruction words
RESET_PC, 32'h0000_0000, PC loaded on reset
FQ_DEPTH, 4, fetch-queue entries; legal range 2..16, power of two
CNT_W, $clog2(FQ_DEPTH)+1, width of occupancy count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active-low
redirect_i  in  1  execute redirect (taken branch/jump)
redirect_pc_i  in  XLEN  redirect target
imem_req_o  out  1  fetch request this cycle
imem_addr_o  out  XLEN  fetch address (current PC)
imem_rdata_i  in  XLEN  instruction; valid the cycle after the matching request
valid_o  out  1  queue head holds a valid instruction
ready_i  in  1  decode accepts head (deasserted when decode stalls)
instr_o  out  XLEN  head instruction
pc_o  out  XLEN  head PC
pc_plus4_o  out  XLEN  head PC + 4
count_o  out  CNT_W  queue occupancy

Behaviour:
- Reset (rst_n low, async):
  - pc = RESET_PC; queue empty; count_o = 0; in-flight flag = 0.
  - valid_o = 0 and imem_req_o = 0 for as long as rst_n is low.
- Credit rule:
  - imem_req_o = rst_n & ~redirect_i & (count + inflight < FQ_DEPTH).
  - Pops in the same cycle do not add credit.
  - imem_addr_o = pc.
- Request cycle: on an edge where imem_req_o = 1, pc <= pc + 4 (mod 2^XLEN, wraps silently) and inflight <= 1. Otherwise inflight <= 0.
- Response:
  - In the cycle after a request, imem_rdata_i is pushed with its request PC at the next edge.
  - The request PC is held in a register alongside the in-flight flag.
  - Memory latency is fixed at 1 cycle.
- Fetch latency: request in cycle t gives valid_o = 1 in cycle t+2 if the queue was empty (push at end of t+1).
- Pop: on an edge with valid_o & ready_i, the head is removed.
- Simultaneous push and pop: both take effect; count unchanged.
- Full: count = FQ_DEPTH, so no request is issued. Credit accounting makes an overflowing push impossible, and the bench asserts it.
- Empty: valid_o = 0; instr_o, pc_o and pc_plus4_o are don't-care but stable.
- Redirect (redirect_i = 1 in cycle t):
  - At the edge ending t, the queue is cleared, count = 0, pc <= redirect_pc_i, and inflight <= 0.
  - Any response present in cycle t is dropped.
  - No request is issued in cycle t.
  - The target is requested in cycle t+1 and is valid at decode in cycle t+3.
- Redirect takes priority over push and pop in the same cycle. A pop handshake in a redirect cycle is still considered consumed by decode.
- Back-to-back redirects: the last one wins.
- Reset asserted mid-operation: immediate return to reset state; the in-flight response is discarded.
- Outputs instr_o, pc_o, pc_plus4_o and valid_o are driven from queue storage (registered). pc_plus4_o = pc_o + 4, computed combinationally.

Test Plan:
1. Reset release, ready_i = 1, imem returns (addr>>2)+0x13: valid_o rises 2 cycles after the first request. pc_o sequence is 0, 4, 8, 12 on consecutive cycles, and instr_o tracks it.
2. ready_i = 0 from the start, FQ_DEPTH = 4: count_o saturates at 4, imem_req_o stays 0 afterwards, and no overflow occurs. Raising ready_i drains 4 entries in order at PCs 0..12, then fetch resumes at 16.
3. Steady stream, redirect_i = 1 with redirect_pc_i = 0x100 while 3 entries are queued: count_o = 0 next cycle and the stale response is dropped. Next valid pc_o = 0x100 appears 3 cycles after the redirect, followed by 0x104.
4. Redirect and pop in the same cycle, and two redirects back to back (0x200 then 0x300): the queue is cleared and only 0x300 onward is delivered.
5. RESET_PC = 0xFFFF_FFF8, XLEN = 32: pc_o sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000. pc_plus4_o for 0xFFFF_FFFC is 0x0000_0000.
6. rst_n pulsed low for half a cycle mid-stream with 2 entries queued: valid_o = 0, count_o = 0 and imem_req_o = 0 immediately. Fetch restarts at RESET_PC and no pre-reset instruction appears.
